// File: rtl/uart_pkg.sv
// Shared UART framing definitions: error codes, parser state encoding and the
// default start-of-frame marker. Also intended for the TX-side frame builder.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } frame_state_e;

    // A LEN byte is legal when it is in 1..max_len.
    function automatic logic len_legal(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// o_terminal on the cycle the count reaches TIMEOUT_CLKS.
module uart_idle_timer #(
    parameter int unsigned TIMEOUT_CLKS = 8680
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // A clear in the terminal cycle suppresses the pulse so an arriving byte wins.
    assign o_terminal = i_enable && !i_clear && (count_q == CW'(TIMEOUT_CLKS - 1));

    always_comb begin
        count_d = '0;
        if (!i_clear && i_enable && !o_terminal) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SYNC/LEN/payload/CHK frames from the uart_rx byte stream, streams the
// payload bytes and reports a registered per-frame status with error counting.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 8680,
    localparam int unsigned IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_rx_dv,
    input  logic [7:0]       i_rx_byte,
    output logic             o_pl_dv,
    output logic [7:0]       o_pl_byte,
    output logic [IDX_W-1:0] o_pl_idx,
    output logic             o_frame_done,
    output logic             o_frame_ok,
    output logic [1:0]       o_err_code,
    output logic [7:0]       o_err_cnt
);

    frame_state_e     state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             pl_dv_q, pl_dv_d;
    logic [7:0]       pl_byte_q, pl_byte_d;
    logic [IDX_W-1:0] pl_idx_q, pl_idx_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [1:0]       code_q, code_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             timeout;

    uart_idle_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_idle_timer (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (i_rx_dv),
        .i_enable  (state_q != ST_IDLE),
        .o_terminal(timeout)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        pl_dv_d   = 1'b0;
        pl_byte_d = '0;
        pl_idx_d  = '0;
        done_d    = 1'b0;
        ok_d      = 1'b0;
        code_d    = ERR_NONE;
        err_cnt_d = err_cnt_q;

        if (i_rx_dv) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_byte == SYNC_BYTE) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (len_legal(i_rx_byte, MAX_LEN)) begin
                        len_d   = i_rx_byte;
                        sum_d   = i_rx_byte;
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        done_d  = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    // SYNC_BYTE inside the payload is ordinary data.
                    pl_dv_d   = 1'b1;
                    pl_byte_d = i_rx_byte;
                    pl_idx_d  = cnt_q;
                    sum_d     = sum_q + i_rx_byte;
                    cnt_d     = cnt_q + 1'b1;
                    if (8'(cnt_q) == len_q - 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (i_rx_byte == sum_q) begin
                        ok_d = 1'b1;
                    end else begin
                        code_d = ERR_CHK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout) begin
            done_d  = 1'b1;
            code_d  = ERR_TMO;
            state_d = ST_IDLE;
        end

        if (done_d && !ok_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            pl_dv_q   <= 1'b0;
            pl_byte_q <= '0;
            pl_idx_q  <= '0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            code_q    <= ERR_NONE;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            pl_dv_q   <= pl_dv_d;
            pl_byte_q <= pl_byte_d;
            pl_idx_q  <= pl_idx_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            code_q    <= code_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_pl_dv      = pl_dv_q;
    assign o_pl_byte    = pl_byte_q;
    assign o_pl_idx     = pl_idx_q;
    assign o_frame_done = done_q;
    assign o_frame_ok   = ok_q;
    assign o_err_code   = code_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed vector table, timeout and
// reset sequences, randomized frames against a frame-level scoreboard, saturation.
module tb_uart_frame_parser;

    localparam int TMO  = 300;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] rxb = 8'h00;
    logic       o_pl_dv;
    logic [7:0] o_pl_byte;
    logic [3:0] o_pl_idx;
    logic       o_frame_done;
    logic       o_frame_ok;
    logic [1:0] o_err_code;
    logic [7:0] o_err_cnt;

    uart_frame_parser #(
        .SYNC_BYTE   (8'hA5),
        .MAX_LEN     (MAXL),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_rx_dv     (dv),
        .i_rx_byte   (rxb),
        .o_pl_dv     (o_pl_dv),
        .o_pl_byte   (o_pl_byte),
        .o_pl_idx    (o_pl_idx),
        .o_frame_done(o_frame_done),
        .o_frame_ok  (o_frame_ok),
        .o_err_code  (o_err_code),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] outs();
        return {o_pl_dv, o_pl_byte, o_pl_idx, o_frame_done, o_frame_ok, o_err_code, o_err_cnt};
    endfunction

    // Drives one byte strobe starting at a negedge; returns at the negedge after
    // the sampling edge, where the registered response is visible.
    task automatic send_byte(input logic [7:0] b);
        dv  = 1'b1;
        rxb = b;
        @(negedge clk);
        dv  = 1'b0;
        rxb = 8'h00;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] b;
        logic       pl_dv;
        logic [7:0] pl_byte;
        logic [3:0] idx;
        logic       done;
        logic       ok;
        logic [1:0] code;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t v(input logic [7:0] b, input logic p, input logic [7:0] pb,
                               input logic [3:0] ix, input logic d, input logic k,
                               input logic [1:0] c, input logic [7:0] e);
        vec_t r;
        r.b = b; r.pl_dv = p; r.pl_byte = pb; r.idx = ix;
        r.done = d; r.ok = k; r.code = c; r.ecnt = e;
        return r;
    endfunction

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            logic [24:0] exp;
            send_byte(tbl[i].b);
            exp = {tbl[i].pl_dv, tbl[i].pl_byte, tbl[i].idx, tbl[i].done,
                   tbl[i].ok, tbl[i].code, tbl[i].ecnt};
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL row%0d byte=%02h: got dv=%0b pl=%02h idx=%0d done=%0b ok=%0b code=%0d ecnt=%0d expected dv=%0b pl=%02h idx=%0d done=%0b ok=%0b code=%0d ecnt=%0d",
                         i, tbl[i].b, o_pl_dv, o_pl_byte, o_pl_idx, o_frame_done, o_frame_ok,
                         o_err_code, o_err_cnt, tbl[i].pl_dv, tbl[i].pl_byte, tbl[i].idx,
                         tbl[i].done, tbl[i].ok, tbl[i].code, tbl[i].ecnt);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    // ---------------- frame-level scoreboard ----------------
    typedef struct {
        bit         done;
        logic [7:0] b;
        logic [3:0] idx;
        bit         ok;
        logic [1:0] code;
        logic [7:0] ecnt;
    } ev_t;

    ev_t        q[$];
    bit         sb_en = 1'b0;
    logic [7:0] exp_err = 8'h00;

    task automatic exp_pl(input logic [7:0] b, input int idx);
        ev_t e;
        e.done = 1'b0; e.b = b; e.idx = 4'(idx); e.ok = 1'b0; e.code = 2'd0; e.ecnt = 8'h00;
        q.push_back(e);
    endtask

    task automatic exp_done(input bit ok, input logic [1:0] code);
        ev_t e;
        if (!ok && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        e.done = 1'b1; e.b = 8'h00; e.idx = 4'd0; e.ok = ok; e.code = code; e.ecnt = exp_err;
        q.push_back(e);
    endtask

    ev_t mon_e;
    always @(negedge clk) begin
        if (sb_en && (o_pl_dv || o_frame_done)) begin
            if (q.size() == 0) begin
                chk("sb_spurious_event", 32'({o_pl_dv, o_frame_done}), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("sb_pl_dv", 32'(o_pl_dv), 32'(!mon_e.done));
                chk("sb_frame_done", 32'(o_frame_done), 32'(mon_e.done));
                if (!mon_e.done) begin
                    chk("sb_pl_byte", 32'(o_pl_byte), 32'(mon_e.b));
                    chk("sb_pl_idx", 32'(o_pl_idx), 32'(mon_e.idx));
                end else begin
                    chk("sb_frame_ok", 32'(o_frame_ok), 32'(mon_e.ok));
                    chk("sb_err_code", 32'(o_err_code), 32'(mon_e.code));
                    chk("sb_err_cnt", 32'(o_err_cnt), 32'(mon_e.ecnt));
                end
            end
        end
    end

    task automatic gap();
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    task automatic rand_frame();
        int         kind;
        int         len;
        int         k;
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] c;
        bit         good;
        kind = $urandom_range(0, 4);
        case (kind)
            0: begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h3C;
                send_byte(b); gap();
            end
            1, 2: begin
                good = (kind == 1);
                len = $urandom_range(1, MAXL);
                send_byte(8'hA5); gap();
                send_byte(8'(len)); gap();
                sum = 8'(len);
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom);
                    sum = sum + b;
                    exp_pl(b, i);
                    send_byte(b); gap();
                end
                c = good ? sum : sum + 8'd1 + 8'($urandom_range(0, 254));
                exp_done(good, good ? 2'd0 : 2'd2);
                send_byte(c); gap();
            end
            3: begin
                b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
                exp_done(1'b0, 2'd1);
                send_byte(8'hA5); gap();
                send_byte(b); gap();
            end
            default: begin
                send_byte(8'hA5); gap();
                if ($urandom_range(0, 3) != 0) begin
                    len = $urandom_range(1, MAXL);
                    send_byte(8'(len)); gap();
                    k = $urandom_range(0, len);
                    for (int i = 0; i < k; i++) begin
                        b = 8'($urandom);
                        exp_pl(b, i);
                        send_byte(b); gap();
                    end
                end
                exp_done(1'b0, 2'd3);
                repeat (TMO + 5) @(negedge clk);
            end
        endcase
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  found;
        bit  saw_done;

        // Test 1, 2, 3, 5 as one continuous byte stream.
        tbl[0]  = v(8'hA5, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = v(8'h03, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[2]  = v(8'h11, 1, 8'h11, 0, 0, 0, 0, 0);
        tbl[3]  = v(8'h22, 1, 8'h22, 1, 0, 0, 0, 0);
        tbl[4]  = v(8'h33, 1, 8'h33, 2, 0, 0, 0, 0);
        tbl[5]  = v(8'h69, 0, 8'h00, 0, 1, 1, 0, 0);
        tbl[6]  = v(8'hA5, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[7]  = v(8'h03, 0, 8'h00, 0, 0, 0, 0, 0);
        tbl[8]  = v(8'h11, 1, 8'h11, 0, 0, 0, 0, 0);
        tbl[9]  = v(8'h22, 1, 8'h22, 1, 0, 0, 0, 0);
        tbl[10] = v(8'h33, 1, 8'h33, 2, 0, 0, 0, 0);
        tbl[11] = v(8'h68, 0, 8'h00, 0, 1, 0, 2, 1);
        tbl[12] = v(8'hA5, 0, 8'h00, 0, 0, 0, 0, 1);
        tbl[13] = v(8'h00, 0, 8'h00, 0, 1, 0, 1, 2);
        tbl[14] = v(8'hA5, 0, 8'h00, 0, 0, 0, 0, 2);
        tbl[15] = v(8'h11, 0, 8'h00, 0, 1, 0, 1, 3);
        tbl[16] = v(8'h00, 0, 8'h00, 0, 0, 0, 0, 3);
        tbl[17] = v(8'hFF, 0, 8'h00, 0, 0, 0, 0, 3);
        tbl[18] = v(8'hA5, 0, 8'h00, 0, 0, 0, 0, 3);
        tbl[19] = v(8'h02, 0, 8'h00, 0, 0, 0, 0, 3);
        tbl[20] = v(8'hA5, 1, 8'hA5, 0, 0, 0, 0, 3);
        tbl[21] = v(8'hA5, 1, 8'hA5, 1, 0, 0, 0, 3);
        tbl[22] = v(8'h4C, 0, 8'h00, 0, 1, 1, 0, 3);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_outputs", 32'(outs()), 32'd0);

        apply_rows(0, 22);

        // Test 4: timeout exactly TMO clocks after the last dv cycle.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        chk("t4_last_payload", 32'({o_pl_dv, o_pl_byte, o_pl_idx}), 32'({1'b1, 8'h10, 4'd0}));
        found = -1;
        for (int j = 1; j <= TMO + 10; j++) begin
            @(negedge clk);
            if (o_frame_done && found < 0) begin
                found = j;
                chk("t4_err_code", 32'(o_err_code), 32'd3);
                chk("t4_frame_ok", 32'(o_frame_ok), 32'd0);
                chk("t4_err_cnt", 32'(o_err_cnt), 32'd4);
            end
        end
        chk("t4_timeout_latency", 32'(found), 32'(TMO));

        // Byte arriving on the terminal-count cycle wins over the timeout.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h77);
        saw_done = 1'b0;
        repeat (TMO - 1) begin
            @(negedge clk);
            if (o_frame_done) saw_done = 1'b1;
        end
        send_byte(8'h88);
        if (o_frame_done) saw_done = 1'b1;
        chk("tc_no_timeout_done", 32'(saw_done), 32'd0);
        chk("tc_byte_processed", 32'({o_pl_dv, o_pl_byte, o_pl_idx}), 32'({1'b1, 8'h88, 4'd1}));
        send_byte(8'h01);
        chk("tc_frame_good", 32'({o_frame_done, o_frame_ok, o_err_code, o_err_cnt}),
            32'({1'b1, 1'b1, 2'd0, 8'd4}));

        // Test 6: reset mid-frame, then test 1 again.
        repeat (3) @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (TMO + 5) begin
            @(negedge clk);
            if (o_frame_done) saw_done = 1'b1;
        end
        chk("t6_no_done_after_reset", 32'(saw_done), 32'd0);
        apply_rows(0, 5);

        // Randomized frames against the scoreboard.
        exp_err = o_err_cnt === 8'd0 ? 8'd0 : 8'd0;
        sb_en = 1'b1;
        for (int f = 0; f < 150; f++) rand_frame();
        repeat (TMO + 10) @(negedge clk);
        chk("sb_all_events_seen", 32'(q.size()), 32'd0);
        sb_en = 1'b0;

        // Saturation of the error counter.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 260; n++) begin
            send_byte(8'hA5);
            send_byte(8'h00);
            chk($sformatf("sat_err_cnt_%0d", n), 32'(o_err_cnt), (n > 255) ? 32'd255 : 32'(n));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
